// File: rtl/zpulse_counter_pkg.sv
// Shared definitions for the pulse-counter glyph streamer: FSM encoding,
// glyph geometry, font ROM layout and RGB565 colours.
package zpulse_counter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StReq,
        StWait,
        StShift,
        StDone
    } state_e;

    localparam int unsigned NumDigits   = 8;
    // 12x24 packed bitmap: 288 pixels = 36 bytes, glyphs packed back to back
    localparam int unsigned GlyphStride = 36;
    localparam int unsigned GlyphBytes  = GlyphStride;
    localparam int unsigned RomAw       = 11;
    localparam logic [10:0] ZeroBase    = 11'd1024;
    localparam logic [15:0] FgColor     = 16'hFFFF;
    localparam logic [15:0] BgColor     = 16'h0000;

    // Map one bitmap bit to its RGB565 colour.
    function automatic logic [15:0] pixel_color(input logic bit_set,
                                                input logic [15:0] fg,
                                                input logic [15:0] bg);
        return bit_set ? fg : bg;
    endfunction

endpackage

// File: rtl/zpulse_counter_glyph_streamer_serializer.sv
// Glyph byte serialiser: holds one font byte, emits it MSB-first as RGB565
// pixels on a valid/ready stream, and flags when bit 0 has been accepted.
module zpulse_glyph_serializer
    import zpulse_counter_pkg::*;
#(
    parameter logic [15:0] FG_COLOR = FgColor,
    parameter logic [15:0] BG_COLOR = BgColor
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [7:0]  data_i,
    input  logic        blank_i,
    input  logic        last_byte_i,
    input  logic        pix_ready_i,
    output logic        pix_valid_o,
    output logic [15:0] pix_data_o,
    output logic        pix_last_o,
    output logic        byte_done_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       valid_q, valid_d;
    logic       blank_q, blank_d;
    logic       last_q, last_d;
    logic       accept;

    assign accept = valid_q & pix_ready_i;

    // Load a fresh byte, or advance one bit per accepted pixel.
    always_comb begin
        shift_d = shift_q;
        bit_d   = bit_q;
        valid_d = valid_q;
        blank_d = blank_q;
        last_d  = last_q;
        if (load_i) begin
            shift_d = data_i;
            bit_d   = 3'd7;
            valid_d = 1'b1;
            blank_d = blank_i;
            last_d  = last_byte_i;
        end else if (accept) begin
            if (bit_q == 3'd0) begin
                valid_d = 1'b0;
            end else begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q - 3'd1;
            end
        end
    end

    // Serialiser state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            last_q  <= last_d;
        end
    end

    // Outputs come straight from registers, so they hold steady during a stall.
    assign pix_valid_o = valid_q;
    assign pix_data_o  = valid_q ? pixel_color(shift_q[7] & ~blank_q, FG_COLOR, BG_COLOR)
                                 : BG_COLOR;
    assign pix_last_o  = valid_q & last_q & (bit_q == 3'd0);
    assign byte_done_o = accept & (bit_q == 3'd0);

endmodule

// File: rtl/zpulse_counter_glyph_streamer.sv
// Pulse-counter glyph streamer: walks the digit mux MSB to LSB, fetches each
// glyph's bytes from the font ROM and streams them as RGB565 pixels.
// Optional build macro ZPC_LEADING_ZERO_BLANK_EN renders leading '0' digits
// (never the last one) in the background colour.
module zpulse_counter_glyph_streamer
    import zpulse_counter_pkg::*;
#(
    parameter int unsigned        NUM_DIGITS  = NumDigits,
    parameter int unsigned        GLYPH_BYTES = GlyphBytes,
    parameter int unsigned        ROM_AW      = RomAw,
    parameter logic [15:0]        FG_COLOR    = FgColor,
    parameter logic [15:0]        BG_COLOR    = BgColor,
    parameter logic [ROM_AW-1:0]  ZERO_BASE   = ROM_AW'(ZeroBase)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        digit_sel_o,
    input  logic [ROM_AW-1:0] glyph_base_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic              rom_en_o,
    input  logic [7:0]        rom_data_i,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic [15:0]       pix_data_o,
    output logic              pix_last_o
);

`ifdef ZPC_LEADING_ZERO_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    localparam int unsigned ByteW = $clog2(GLYPH_BYTES);

    state_e            state_q, state_d;
    logic [3:0]        digit_q, digit_d;
    logic [ByteW-1:0]  byte_q, byte_d;
    logic [ROM_AW-1:0] base_q, base_d;
    logic              blank_q, blank_d;
    // Still inside the leading run of blanked digits
    logic              run_q, run_d;

    logic              last_digit;
    logic              last_byte;
    logic              sel_blank;
    logic              byte_done;

    assign last_digit = (digit_q == 4'(NUM_DIGITS - 1));
    assign last_byte  = (byte_q == ByteW'(GLYPH_BYTES - 1));
    assign sel_blank  = BlankEn & run_q & (glyph_base_i == ZERO_BASE) & ~last_digit;

    // Next-state logic for digit/byte sequencing.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        byte_d  = byte_q;
        base_d  = base_q;
        blank_d = blank_q;
        run_d   = run_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSel;
                    digit_d = 4'd0;
                    run_d   = 1'b1;
                end
            end
            StSel: begin
                base_d  = glyph_base_i;
                byte_d  = '0;
                blank_d = sel_blank;
                run_d   = sel_blank;
                state_d = StReq;
            end
            StReq:  state_d = StWait;
            StWait: state_d = StShift;
            StShift: begin
                if (byte_done) begin
                    if (!last_byte) begin
                        byte_d  = byte_q + ByteW'(1);
                        state_d = StReq;
                    end else if (!last_digit) begin
                        digit_d = digit_q + 4'd1;
                        state_d = StSel;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            digit_q <= 4'd0;
            byte_q  <= '0;
            base_q  <= '0;
            blank_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            byte_q  <= byte_d;
            base_q  <= base_d;
            blank_q <= blank_d;
            run_q   <= run_d;
        end
    end

    assign busy_o      = (state_q == StSel) | (state_q == StReq) |
                         (state_q == StWait) | (state_q == StShift);
    assign done_o      = (state_q == StDone);
    assign digit_sel_o = digit_q;
    assign rom_en_o    = (state_q == StReq);
    // Address arithmetic wraps at the ROM size
    assign rom_addr_o  = base_q + ROM_AW'(byte_q);

    zpulse_glyph_serializer #(
        .FG_COLOR (FG_COLOR),
        .BG_COLOR (BG_COLOR)
    ) u_serializer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (state_q == StWait),
        .data_i      (rom_data_i),
        .blank_i     (blank_q),
        .last_byte_i (last_digit & last_byte),
        .pix_ready_i (pix_ready_i),
        .pix_valid_o (pix_valid_o),
        .pix_data_o  (pix_data_o),
        .pix_last_o  (pix_last_o),
        .byte_done_o (byte_done)
    );

endmodule

// File: tb/tb_zpulse_counter_glyph_streamer.sv
// Self-checking bench for zpulse_counter_glyph_streamer with a digit-mux and
// font-ROM model. Honours ZPC_LEADING_ZERO_BLANK_EN for the blanking check.
module tb_zpulse_counter_glyph_streamer;

`ifdef ZPC_LEADING_ZERO_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    localparam int FieldPix = 2304;
    localparam int Budget   = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  digit_sel;
    logic [10:0] glyph_base;
    logic [10:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data = 8'd0;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_last;

    logic [3:0]  dv [8];
    bit          rom_a5;

    int passed = 0;
    int total  = 0;

    logic [15:0] got [$];
    int last_cnt, last_pos, done_cnt, done_gap, first_lat, first_addr;
    int stall_err, rom_en_cnt, rom_en_back, timed_out;
    int first_bad;

    always #5 clk = ~clk;

    zpulse_counter_glyph_streamer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .digit_sel_o  (digit_sel),
        .glyph_base_i (glyph_base),
        .rom_addr_o   (rom_addr),
        .rom_en_o     (rom_en),
        .rom_data_i   (rom_data),
        .pix_valid_o  (pix_valid),
        .pix_ready_i  (pix_ready),
        .pix_data_o   (pix_data),
        .pix_last_o   (pix_last)
    );

    // Digit mux model: glyph for value v lives at 1024 + 36*v
    assign glyph_base = 11'(1024 + 36 * int'(dv[digit_sel[2:0]]));

    // Font ROM model, one-cycle read latency
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_a5 ? 8'hA5 : rom_addr[7:0];
    end

    function automatic logic [15:0] model_pix(input int idx);
        int d, b, k;
        logic [10:0] addr;
        logic [7:0]  byt;
        bit run, blank;
        d = idx / 288;
        b = (idx % 288) / 8;
        k = idx % 8;
        run = 1'b1;
        blank = 1'b0;
        for (int i = 0; i <= d; i++) begin
            blank = BlankEn && run && (dv[i] == 4'd0) && (i != 7);
            run = blank;
        end
        addr = 11'(1024 + 36 * int'(dv[d]) + b);
        byt = rom_a5 ? 8'hA5 : addr[7:0];
        return (!blank && byt[7-k]) ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic int count_mism();
        int n = 0;
        first_bad = -1;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== model_pix(i)) begin
                n++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return n;
    endfunction

    // Pulse start, then run the stream until done (+3 cycles), reset or timeout.
    task automatic collect(input bit stall, input int rst_at, input int extra_start_at);
        logic [15:0] held_d;
        logic held_l;
        bit held_v, prev_en, stop;
        int c, last_acc, done_c;
        got.delete();
        last_cnt = 0; last_pos = -1; done_cnt = 0; done_gap = -1;
        first_lat = -1; first_addr = -1; stall_err = 0; rom_en_cnt = 0;
        rom_en_back = 0; timed_out = 0;
        held_v = 1'b0; held_d = '0; held_l = 1'b0; prev_en = 1'b0;
        last_acc = 0; done_c = -1; stop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        pix_ready = 1'b0;
        c = 0;
        while (!stop) begin
            @(negedge clk);
            c++;
            start = (c == extra_start_at);
            if (rst_at >= 0 && got.size() == rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                pix_ready = 1'b0;
                @(negedge clk);
                stop = 1'b1;
            end else begin
                if (done) begin
                    done_cnt++;
                    if (done_c < 0) begin
                        done_c = c;
                        done_gap = c - last_acc;
                    end
                end
                pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rom_en) begin
                    rom_en_cnt++;
                    if (first_addr < 0) first_addr = int'(rom_addr);
                    if (prev_en) rom_en_back++;
                end
                prev_en = rom_en;
                if (held_v && (!pix_valid || pix_data !== held_d || pix_last !== held_l))
                    stall_err++;
                if (pix_valid && first_lat < 0) first_lat = c;
                if (pix_valid && pix_ready) begin
                    got.push_back(pix_data);
                    if (pix_last) begin
                        last_cnt++;
                        last_pos = got.size() - 1;
                    end
                    last_acc = c;
                end
                held_v = pix_valid && !pix_ready;
                held_d = pix_data;
                held_l = pix_last;
                if (done_c >= 0 && c == done_c + 3) stop = 1'b1;
                if (c > Budget) begin
                    timed_out = 1;
                    stop = 1'b1;
                end
            end
        end
        start = 1'b0;
        pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (digit_sel !== 4'd0) $display("FAIL reset_digit_sel got=%0d exp=0", digit_sel);
        else passed++;
        total++; if (rom_addr !== 11'd0) $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr);
        else passed++;
        total++; if (rom_en !== 1'b0) $display("FAIL reset_rom_en got=%b exp=0", rom_en); else passed++;
        total++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid got=%b exp=0", pix_valid);
        else passed++;
        total++; if (pix_data !== 16'h0000) $display("FAIL reset_pix_data got=%h exp=0000", pix_data);
        else passed++;
        total++; if (pix_last !== 1'b0) $display("FAIL reset_pix_last got=%b exp=0", pix_last);
        else passed++;
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_field();
        int m;
        for (int i = 0; i < 8; i++) dv[i] = 4'(i + 1);
        rom_a5 = 1'b0;
        collect(1'b0, -1, -1);
        total++; if (timed_out != 0) $display("FAIL full_timeout got=%0d exp=0", timed_out); else passed++;
        total++; if (first_addr != 1060) $display("FAIL full_first_addr got=%0d exp=1060", first_addr);
        else passed++;
        total++; if (first_lat != 4) $display("FAIL full_first_latency got=%0d exp=4", first_lat);
        else passed++;
        total++; if (got.size() != FieldPix) $display("FAIL full_pix_count got=%0d exp=%0d",
                                                      got.size(), FieldPix); else passed++;
        m = count_mism();
        total++; if (m != 0) $display("FAIL full_pix_seq mism=%0d first_idx=%0d exp=0", m, first_bad);
        else passed++;
        total++; if (last_cnt != 1 || last_pos != FieldPix - 1)
            $display("FAIL full_pix_last got=%0d@%0d exp=1@%0d", last_cnt, last_pos, FieldPix - 1);
        else passed++;
        total++; if (done_cnt != 1 || done_gap != 1)
            $display("FAIL full_done got=%0d gap=%0d exp=1 gap=1", done_cnt, done_gap); else passed++;
        total++; if (rom_en_cnt != 288 || rom_en_back != 0)
            $display("FAIL full_rom_en got=%0d back=%0d exp=288 back=0", rom_en_cnt, rom_en_back);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL full_busy_after got=%b exp=0", busy); else passed++;
        total++; if (digit_sel !== 4'd7) $display("FAIL full_digit_sel_hold got=%0d exp=7", digit_sel);
        else passed++;
    endtask

    task automatic test_stall();
        int m;
        for (int i = 0; i < 8; i++) dv[i] = 4'(i + 1);
        rom_a5 = 1'b0;
        collect(1'b1, -1, -1);
        total++; if (got.size() != FieldPix) $display("FAIL stall_pix_count got=%0d exp=%0d",
                                                      got.size(), FieldPix); else passed++;
        m = count_mism();
        total++; if (m != 0) $display("FAIL stall_pix_seq mism=%0d first_idx=%0d exp=0", m, first_bad);
        else passed++;
        total++; if (stall_err != 0) $display("FAIL stall_hold got=%0d exp=0", stall_err); else passed++;
        total++; if (last_cnt != 1 || last_pos != FieldPix - 1)
            $display("FAIL stall_pix_last got=%0d@%0d exp=1@%0d", last_cnt, last_pos, FieldPix - 1);
        else passed++;
        total++; if (done_cnt != 1) $display("FAIL stall_done got=%0d exp=1", done_cnt); else passed++;
    endtask

    task automatic test_pattern_a5();
        logic [15:0] exp8 [8];
        int m;
        exp8 = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 8; i++) dv[i] = 4'(i + 1);
        rom_a5 = 1'b1;
        collect(1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got.size() <= i || got[i] !== exp8[i])
                $display("FAIL a5_pixel_%0d got=%h exp=%h", i, (got.size() > i) ? got[i] : 16'hxxxx,
                         exp8[i]);
            else passed++;
        end
        m = count_mism();
        total++; if (m != 0 || got.size() != FieldPix)
            $display("FAIL a5_pix_seq mism=%0d count=%0d exp=0 count=%0d", m, got.size(), FieldPix);
        else passed++;
        rom_a5 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int late_done = 0;
        int m;
        for (int i = 0; i < 8; i++) dv[i] = 4'(i + 1);
        rom_a5 = 1'b0;
        collect(1'b0, 1000, -1);
        total++; if (got.size() != 1000) $display("FAIL rstmid_reached got=%0d exp=1000", got.size());
        else passed++;
        total++; if (pix_valid !== 1'b0) $display("FAIL rstmid_pix_valid got=%b exp=0", pix_valid);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
        total++; if (rom_addr !== 11'd0) $display("FAIL rstmid_rom_addr got=%0d exp=0", rom_addr);
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        total++; if (done_cnt + late_done != 0)
            $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt + late_done); else passed++;
        collect(1'b0, -1, -1);
        m = count_mism();
        total++; if (got.size() != FieldPix || m != 0 || done_cnt != 1)
            $display("FAIL rstmid_rerun count=%0d mism=%0d done=%0d exp count=%0d mism=0 done=1",
                     got.size(), m, done_cnt, FieldPix);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 8; i++) dv[i] = 4'(8 - i);
        rom_a5 = 1'b0;
        collect(1'b0, -1, 500);
        total++; if (done_cnt != 1) $display("FAIL busy_start_done got=%0d exp=1", done_cnt);
        else passed++;
        total++; if (got.size() != FieldPix) $display("FAIL busy_start_count got=%0d exp=%0d",
                                                      got.size(), FieldPix); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL busy_start_idle got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_blank();
        int fg_lead = 0;
        int fg_last = 0;
        int m;
        for (int i = 0; i < 8; i++) dv[i] = 4'd0;
        rom_a5 = 1'b0;
        collect(1'b0, -1, -1);
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] == 16'hFFFF) begin
                if (i < 7 * 288) fg_lead++;
                else fg_last++;
            end
        end
        // Glyph '0' bytes are 0x00..0x23: 88 set bits per digit
        total++; if (fg_lead != (BlankEn ? 0 : 616))
            $display("FAIL blank_lead_fg got=%0d exp=%0d", fg_lead, BlankEn ? 0 : 616);
        else passed++;
        total++; if (fg_last != 88) $display("FAIL blank_last_fg got=%0d exp=88", fg_last);
        else passed++;
        m = count_mism();
        total++; if (m != 0 || got.size() != FieldPix)
            $display("FAIL blank_pix_seq mism=%0d count=%0d exp=0 count=%0d", m, got.size(), FieldPix);
        else passed++;
        // One non-zero digit ends the leading run: later zeros are drawn
        dv[3] = 4'd5;
        collect(1'b0, -1, -1);
        m = count_mism();
        total++; if (m != 0 || got.size() != FieldPix)
            $display("FAIL blank_run_seq mism=%0d count=%0d exp=0 count=%0d", m, got.size(), FieldPix);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        rom_a5 = 1'b0;
        for (int i = 0; i < 8; i++) dv[i] = 4'd0;
        test_reset();
        test_full_field();
        test_stall();
        test_pattern_a5();
        test_reset_mid();
        test_start_while_busy();
        test_blank();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
